// File: rtl/btn_cond_pkg.sv
// -----------------------------------------------------------------------------
// btn_cond_pkg
// Shared defaults for the button / external-reset conditioner.
//   BTN_COND_SYNC_STAGES_DFLT : default synchronizer depth (legal 2..4)
//   BTN_COND_DEBOUNCE_DFLT    : default number of consecutive synchronized-high
//                               cycles required before the output asserts
// -----------------------------------------------------------------------------
package btn_cond_pkg;

    localparam int BTN_COND_SYNC_STAGES_DFLT = 32'sd2;
    localparam int BTN_COND_DEBOUNCE_DFLT    = 32'sd65536;

endpackage : btn_cond_pkg

// File: rtl/sync_ff.sv
// -----------------------------------------------------------------------------
// sync_ff
// N-stage flop synchronizer for a single asynchronous bit. Every stage resets
// asynchronously to 0, so the synchronized output reads low during reset.
// Ports:
//   clk   in  1  destination clock
//   rst_n in  1  asynchronous active-low reset
//   d     in  1  asynchronous input
//   q     out 1  synchronized output (last stage)
// -----------------------------------------------------------------------------
module sync_ff #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [N-1:0] stages_r;

    // Shift the raw input through the synchronizer chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stages_r <= {N{1'b0}};
        end else begin
            stages_r <= {stages_r[N-2:0], d};
        end
    end

    assign q = stages_r[N-1];

endmodule : sync_ff

// File: rtl/btn_debounce_cond.sv
// -----------------------------------------------------------------------------
// btn_debounce_cond
// Synchronizes and debounces one asynchronous active-high button / external
// reset request. A press is accepted only after DEBOUNCE_CYCLES consecutive
// synchronized-high samples; a release is honoured on the first synchronized
// low sample. The counter saturates, so a held input never retriggers.
//
// Ports:
//   clk         in  1  system clock, all state on the rising edge
//   rst_n       in  1  asynchronous active-low reset
//   btn         in  1  raw asynchronous input, active high
//   out         out 1  debounced, synchronized level, active high
//   press_pulse out 1  one-cycle strobe on the 0->1 transition of out
//                      (only present when BTN_COND_PRESS_PULSE_EN is defined)
//
// Optional feature macro: BTN_COND_PRESS_PULSE_EN
// -----------------------------------------------------------------------------
module btn_debounce_cond
    import btn_cond_pkg::*;
#(
    parameter  int SYNC_STAGES     = BTN_COND_SYNC_STAGES_DFLT,
    parameter  int DEBOUNCE_CYCLES = BTN_COND_DEBOUNCE_DFLT,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
`ifdef BTN_COND_PRESS_PULSE_EN
    output logic out,
    output logic press_pulse
`else
    output logic out
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             btn_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             out_r;

    sync_ff #(
        .N (SYNC_STAGES)
    ) u_sync_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn),
        .q     (btn_s)
    );

    // Next counter value: clear on any low sample, count up, saturate at max.
    always_comb begin
        cnt_next_s = cnt_r;
        if (!btn_s) begin
            cnt_next_s = {CNT_W{1'b0}};
        end else if (cnt_r != CNT_MAX) begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Counter and output register. out_r is loaded with the decode of the
    // counter's next value, so it tracks (cnt_r == CNT_MAX) cycle for cycle
    // while coming straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
            out_r <= 1'b0;
        end else begin
            cnt_r <= cnt_next_s;
            out_r <= (cnt_next_s == CNT_MAX);
        end
    end

    assign out = out_r;

`ifdef BTN_COND_PRESS_PULSE_EN
    logic out_d_r;

    // Delayed copy of out for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_d_r <= 1'b0;
        end else begin
            out_d_r <= out_r;
        end
    end

    // High only in the first cycle of out being set; reset clears both terms.
    assign press_pulse = out_r & ~out_d_r;
`endif

endmodule : btn_debounce_cond

// File: tb/tb_btn_debounce_cond.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce_cond
// Directed bench for btn_debounce_cond with SYNC_STAGES=2, DEBOUNCE_CYCLES=8.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so "after k edges" means k rising edges after btn changed.
// -----------------------------------------------------------------------------
module tb_btn_debounce_cond;

    logic clk;
    logic rst_n;
    logic btn;
    logic out;
`ifdef BTN_COND_PRESS_PULSE_EN
    logic press_pulse;
`endif

    int vectors     = 0;
    int miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    btn_debounce_cond #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn         (btn),
`ifdef BTN_COND_PRESS_PULSE_EN
        .out         (out),
        .press_pulse (press_pulse)
`else
        .out         (out)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic obs, input logic exp_v);
        vectors++;
        assert (obs === exp_v)
        else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    task automatic check_state(input string tag, input logic exp_out, input logic exp_pp);
        check({tag, "/out"}, out, exp_out);
`ifdef BTN_COND_PRESS_PULSE_EN
        check({tag, "/press_pulse"}, press_pulse, exp_pp);
`else
        if (exp_pp === 1'bx) $display("unreachable");
`endif
    endtask

    // btn has just gone (or is already) high and will be sampled at the next
    // edge: out must stay low for 9 edges and rise on the 10th.
    task automatic press_run(input string tag);
        for (int i = 1; i <= 9; i++) begin
            tick();
            check_state({tag, "_wait"}, 1'b0, 1'b0);
        end
        tick();
        check_state({tag, "_rise"}, 1'b1, 1'b1);
    endtask

    // btn has just gone low: out stays high for 2 edges and falls on the 3rd.
    task automatic release_run(input string tag);
        for (int i = 1; i <= 2; i++) begin
            tick();
            check_state({tag, "_hold"}, 1'b1, 1'b0);
        end
        tick();
        check_state({tag, "_fall"}, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset with btn high: out must remain low throughout.
        rst_n = 1'b0;
        btn   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_state("reset", 1'b0, 1'b0);
        end

        // Release reset with btn held: full press latency from release.
        rst_n = 1'b1;
        press_run("rst_release");
        for (int i = 0; i < 5; i++) begin
            tick();
            check_state("rst_release_held", 1'b1, 1'b0);
        end
        btn = 1'b0;
        release_run("rst_release_rel");
        tick();
        tick();

        // Clean press for 20 cycles, then release.
        btn = 1'b1;
        press_run("clean");
        for (int i = 0; i < 10; i++) begin
            tick();
            check_state("clean_held", 1'b1, 1'b0);
        end
        btn = 1'b0;
        release_run("clean_rel");
        tick();
        tick();

        // Bounce: 5 high, 1 low, then high; only the second rise may count.
        btn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_state("bounce_first", 1'b0, 1'b0);
        end
        btn = 1'b0;
        tick();
        check_state("bounce_low", 1'b0, 1'b0);
        btn = 1'b1;
        press_run("bounce_second");

        // Long hold: out stays high, counter pinned at 8.
        for (int i = 0; i < 1000; i++) begin
            tick();
            check_state("long_hold", 1'b1, 1'b0);
            vectors++;
            assert (dut.cnt_r === 4'd8)
            else begin
                miscompares++;
                $error("FAIL long_hold_cnt: observed %0d expected 8", dut.cnt_r);
            end
        end

        // Asynchronous reset while out=1: out drops before any clock edge.
        rst_n = 1'b0;
        #1;
        check_state("async_rst_now", 1'b0, 1'b0);
        tick();
        check_state("async_rst_edge", 1'b0, 1'b0);
        rst_n = 1'b1;
        press_run("async_rst_recover");
        btn = 1'b0;
        release_run("final_rel");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: observed no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_btn_debounce_cond
